// File: rtl/pipe_skid_stage_pkg.sv
// rtl/pipe_skid_stage_pkg.sv - shared state encoding and constants for the skid stage
package pipe_skid_stage_pkg;

  typedef logic [1:0] stage_state_t;

  // Encoding doubles as the stored-entry count.
  localparam stage_state_t ST_EMPTY = 2'd0;
  localparam stage_state_t ST_ONE   = 2'd1;
  localparam stage_state_t ST_FULL  = 2'd2;

  localparam int unsigned MAX_DATA_W = 512;
  localparam logic [MAX_DATA_W-1:0] ZERO_PAYLOAD = '0;

  function automatic logic [1:0] occupancy_of(stage_state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// rtl/pipe_skid_stage_if.sv - upstream/downstream handshake bundle of the skid stage
interface pipe_skid_stage_if #(
  parameter int DATA_W = 160,
  parameter int ADDR_W = 32
);
  logic              up_valid_i;
  logic              up_ready_o;
  logic [DATA_W-1:0] up_payload_i;
  logic [ADDR_W-1:0] up_pc_i;
  logic              up_branch_tag_i;
  logic              up_slot_end_i;
  logic              dn_valid_o;
  logic              dn_ready_i;
  logic [DATA_W-1:0] dn_payload_o;
  logic [ADDR_W-1:0] dn_pc_o;
  logic [1:0]        occupancy_o;

  modport master (
    output up_valid_i, up_payload_i, up_pc_i, up_branch_tag_i, up_slot_end_i, dn_ready_i,
    input  up_ready_o, dn_valid_o, dn_payload_o, dn_pc_o, occupancy_o
  );

  modport slave (
    input  up_valid_i, up_payload_i, up_pc_i, up_branch_tag_i, up_slot_end_i, dn_ready_i,
    output up_ready_o, dn_valid_o, dn_payload_o, dn_pc_o, occupancy_o
  );
endinterface

// File: rtl/pipe_branch_tracker.sv
// rtl/pipe_branch_tracker.sv - branch-shadow flag and PC; substitutes the shadow PC on accept
module pipe_branch_tracker #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              accept,
  input  logic              tag,
  input  logic              slot_end,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] eff_pc,
  output logic              flag
);
  logic [ADDR_W-1:0] shadow_pc;

  assign eff_pc = flag ? shadow_pc : pc;

  // A tagged entry wins over slot_end so a self-looping branch keeps its shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag      <= 1'b0;
      shadow_pc <= '0;
    end else if (flush) begin
      flag      <= 1'b0;
      shadow_pc <= '0;
    end else if (accept) begin
      if (tag) begin
        flag      <= 1'b1;
        shadow_pc <= pc;
      end else if (slot_end) begin
        flag      <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid (or single register) pipeline stage with branch-shadow PC
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W  = 160,
  parameter int ADDR_W  = 32,
  parameter int SKID_EN = 1
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic               flush_i,
  pipe_skid_stage_if.slave   bus
);
  localparam logic [DATA_W-1:0] PL_ZERO = ZERO_PAYLOAD[DATA_W-1:0];

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] head_pl_q, head_pl_d, skid_pl_q, skid_pl_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0] eff_pc;
  logic              ready_q, up_ready, dn_valid, accept, pop;
  logic              shadow_flag;

  assign dn_valid = (state_q != ST_EMPTY);
  assign up_ready = (SKID_EN != 0) ? ready_q : (!dn_valid || bus.dn_ready_i);
  assign accept   = bus.up_valid_i && up_ready;
  assign pop      = dn_valid && bus.dn_ready_i;

  pipe_branch_tracker #(.ADDR_W(ADDR_W)) u_branch (
    .clk      (clk_i),
    .rst_n    (n_rst_i),
    .flush    (flush_i),
    .accept   (accept),
    .tag      (bus.up_branch_tag_i),
    .slot_end (bus.up_slot_end_i),
    .pc       (bus.up_pc_i),
    .eff_pc   (eff_pc),
    .flag     (shadow_flag)
  );

  always_comb begin
    state_d   = state_q;
    head_pl_d = head_pl_q;
    head_pc_d = head_pc_q;
    skid_pl_d = skid_pl_q;
    skid_pc_d = skid_pc_q;
    if (flush_i) begin
      state_d   = ST_EMPTY;
      head_pl_d = PL_ZERO;
      head_pc_d = '0;
      skid_pl_d = PL_ZERO;
      skid_pc_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            head_pl_d = bus.up_payload_i;
            head_pc_d = eff_pc;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_pl_d = bus.up_payload_i;
            head_pc_d = eff_pc;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_pl_d = bus.up_payload_i;
            skid_pc_d = eff_pc;
          end else if (pop) begin
            state_d   = ST_EMPTY;
            head_pl_d = PL_ZERO;
            head_pc_d = '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d   = ST_ONE;
            head_pl_d = skid_pl_q;
            head_pc_d = skid_pc_q;
            skid_pl_d = PL_ZERO;
            skid_pc_d = '0;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          head_pl_d = PL_ZERO;
          head_pc_d = '0;
          skid_pl_d = PL_ZERO;
          skid_pc_d = '0;
        end
      endcase
    end
  end

  // ready_q looks one state ahead so up_ready never depends on dn_ready_i in skid mode.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q   <= ST_EMPTY;
      head_pl_q <= PL_ZERO;
      head_pc_q <= '0;
      skid_pl_q <= PL_ZERO;
      skid_pc_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      head_pl_q <= head_pl_d;
      head_pc_q <= head_pc_d;
      skid_pl_q <= skid_pl_d;
      skid_pc_q <= skid_pc_d;
      ready_q   <= (state_d != ST_FULL);
    end
  end

  assign bus.up_ready_o   = up_ready;
  assign bus.dn_valid_o   = dn_valid;
  assign bus.dn_payload_o = dn_valid ? head_pl_q : PL_ZERO;
  assign bus.dn_pc_o      = dn_valid ? head_pc_q : '0;
  assign bus.occupancy_o  = occupancy_of(state_q);
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - scoreboard bench for pipe_skid_stage (skid and single-register builds)
module tb_pipe_skid_stage;
  localparam int DW = 160;
  localparam int AW = 32;

  typedef struct {
    logic [DW-1:0] pl;
    logic [AW-1:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  pipe_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  pipe_skid_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  pipe_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID_EN(1)) dut (
    .clk_i(clk), .n_rst_i(rst_n), .flush_i(flush), .bus(bus)
  );
  pipe_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID_EN(0)) dut0 (
    .clk_i(clk), .n_rst_i(rst_n), .flush_i(flush), .bus(bus0)
  );

  entry_t        sb[$];
  int            tests = 0;
  int            fails = 0;
  logic          mflag = 1'b0;
  logic [AW-1:0] mpc = '0;

  task automatic check(string tag, logic [191:0] obs, logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [DW-1:0] pl, logic [AW-1:0] pc, bit tag, bit se, bit rdy);
    bus.up_valid_i      = v;
    bus.up_payload_i    = pl;
    bus.up_pc_i         = pc;
    bus.up_branch_tag_i = tag;
    bus.up_slot_end_i   = se;
    bus.dn_ready_i      = rdy;
  endtask

  task automatic drive0(bit v, logic [DW-1:0] pl, bit rdy);
    bus0.up_valid_i      = v;
    bus0.up_payload_i    = pl;
    bus0.up_pc_i         = '0;
    bus0.up_branch_tag_i = 1'b0;
    bus0.up_slot_end_i   = 1'b0;
    bus0.dn_ready_i      = rdy;
  endtask

  // One clock of the skid build: score the handshakes, advance, then check invariants.
  task automatic tick();
    bit     acc, pop;
    entry_t e;
    #1;
    acc = bus.up_valid_i && bus.up_ready_o;
    pop = bus.dn_valid_o && bus.dn_ready_i;
    if (flush) begin
      sb.delete();
      mflag = 1'b0;
      mpc   = '0;
    end else begin
      if (pop) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL pop_unexpected observed=%0h expected=empty", bus.dn_payload_o);
        end else begin
          e = sb.pop_front();
          check("pop_payload", bus.dn_payload_o, e.pl);
          check("pop_pc", bus.dn_pc_o, e.pc);
        end
      end
      if (acc) begin
        e.pl = bus.up_payload_i;
        e.pc = mflag ? mpc : bus.up_pc_i;
        if (bus.up_branch_tag_i) begin
          mflag = 1'b1;
          mpc   = bus.up_pc_i;
        end else if (mflag && bus.up_slot_end_i) begin
          mflag = 1'b0;
        end
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("occupancy", bus.occupancy_o, sb.size());
    check("up_ready", bus.up_ready_o, sb.size() < 2);
    check("dn_valid", bus.dn_valid_o, sb.size() != 0);
    check("shadow_flag", dut.u_branch.flag, mflag);
    if (sb.size() == 0) check("bubble", {bus.dn_payload_o, bus.dn_pc_o}, 192'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, pop1, acc0, pop0;
    logic [31:0] br_pc[4];
    drive(0, '0, '0, 0, 0, 0);
    drive0(0, '0, 0);
    repeat (2) @(negedge clk);
    check("rst_dn_valid", bus.dn_valid_o, 0);
    check("rst_up_ready", bus.up_ready_o, 1);
    check("rst_occupancy", bus.occupancy_o, 0);
    check("rst_payload", bus.dn_payload_o, 0);
    check("rst_pc", bus.dn_pc_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // fill and drain
    drive(1, 'h1, 'h10, 0, 0, 0); tick();
    check("fill1_ready", bus.up_ready_o, 1);
    drive(1, 'h2, 'h14, 0, 0, 0); tick();
    check("fill2_ready_drop", bus.up_ready_o, 0);
    drive(1, 'h3, 'h18, 0, 0, 0); tick();
    check("fill3_held_occ", bus.occupancy_o, 2);
    check("fill3_head", bus.dn_payload_o, 'h1);
    drive(1, 'h3, 'h18, 0, 0, 1); tick();
    check("drain1_head", bus.dn_payload_o, 'h2);
    tick();
    drive(0, '0, '0, 0, 0, 1); tick();
    tick();

    // branch shadow
    br_pc = '{32'h100, 32'h104, 32'h200, 32'h204};
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(i + 'h20), br_pc[i], i == 0, i == 2, 1);
      tick();
      check("branch_pc", bus.dn_pc_o, (i == 3) ? 32'h204 : 32'h100);
    end
    drive(0, '0, '0, 0, 0, 1); tick();

    // self-loop branch
    for (int i = 0; i < 3; i++) begin
      drive(1, DW'(i + 'h30), 'h80, 1, 1, 1);
      tick();
      check("selfloop_pc", bus.dn_pc_o, 'h80);
      check("selfloop_flag", dut.u_branch.flag, 1);
    end
    drive(0, '0, '0, 0, 0, 1); tick();

    // flush beats accept and pop while full
    drive(1, 'hA, 'h300, 0, 0, 0); tick();
    drive(1, 'hB, 'h304, 0, 0, 0); tick();
    check("pre_flush_occ", bus.occupancy_o, 2);
    flush = 1'b1;
    drive(1, 'hC, 'h308, 0, 0, 1); tick();
    flush = 1'b0;
    check("flush_dn_valid", bus.dn_valid_o, 0);
    check("flush_payload", bus.dn_payload_o, 0);
    check("flush_occ", bus.occupancy_o, 0);
    check("flush_ready", bus.up_ready_o, 1);
    check("flush_flag", dut.u_branch.flag, 0);

    // asynchronous reset while holding one entry
    drive(1, 'hD, 'h400, 1, 0, 0); tick();
    drive(0, '0, '0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dn_valid", bus.dn_valid_o, 0);
    check("arst_pc", bus.dn_pc_o, 0);
    check("arst_occ", bus.occupancy_o, 0);
    check("arst_ready", bus.up_ready_o, 1);
    check("arst_flag", dut.u_branch.flag, 0);
    sb.delete();
    mflag = 1'b0;
    mpc   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 'hE, 'h500, 0, 0, 1); tick();
    check("post_rst_head", bus.dn_payload_o, 'hE);
    check("post_rst_pc", bus.dn_pc_o, 'h500);
    drive(0, '0, '0, 0, 0, 1); tick();

    // throughput on both builds
    acc1 = 0; pop1 = 0; acc0 = 0; pop0 = 0;
    for (int i = 0; i <= 100; i++) begin
      drive(i < 100, DW'(i + 1), AW'(i * 4), 0, 0, 1);
      drive0(i < 100, DW'(i + 1), 1);
      #1;
      if (bus0.dn_valid_o && bus0.dn_ready_i) begin
        pop0++;
        check("tp0_order", bus0.dn_payload_o, pop0);
      end
      if (bus0.up_valid_i && bus0.up_ready_o) acc0++;
      if (bus.dn_valid_o && bus.dn_ready_i) pop1++;
      if (bus.up_valid_i && bus.up_ready_o) acc1++;
      tick();
      check("tp_occ_skid", bus.occupancy_o < 2, 1);
      check("tp_occ_single", bus0.occupancy_o < 2, 1);
    end
    check("tp_acc_skid", acc1, 100);
    check("tp_pop_skid", pop1, 100);
    check("tp_acc_single", acc0, 100);
    check("tp_pop_single", pop0, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 160: payload width in bits, legal range 1..512.
REQ-002 Parameter ADDR_W, default 32: instruction address width.
REQ-003 Parameter SKID_EN, default 1. 1 = two-entry skid buffer. 0 = single-entry register, where up_ready_o = !dn_valid_o || dn_ready_i.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 n_rst_i  input  1  reset, asynchronous and active-low.
REQ-006 flush_i  input  1  synchronous pipeline flush.
REQ-007 up_valid_i  input  1  upstream entry valid.
REQ-008 up_ready_o  output  1  stage can accept an entry.
REQ-009 up_payload_i  input  DATA_W  opaque payload (rd, mem, csr, exception fields).
REQ-010 up_pc_i  input  ADDR_W  instruction address.
REQ-011 up_branch_tag_i  input  1  the entry is a branch.
REQ-012 up_slot_end_i  input  1  the entry is the first instruction fetched from the branch target.
REQ-013 dn_valid_o  output  1  downstream entry valid.
REQ-014 dn_ready_i  input  1  downstream accepts the entry.
REQ-015 dn_payload_o  output  DATA_W  head payload.
REQ-016 dn_pc_o  output  ADDR_W  head address, after branch-shadow substitution.
REQ-017 occupancy_o  output  2  number of stored entries (0..2).

Function
REQ-018 An entry is accepted when up_valid_i && up_ready_o. An entry is popped when dn_valid_o && dn_ready_i.
REQ-019 Latency: an entry accepted into an empty stage appears on dn_* in the next cycle.
REQ-020 Ordering is strict FIFO; no entry is dropped or duplicated.
REQ-021 States and transitions:
- EMPTY: accept -> ONE.
- ONE: accept only -> FULL. Pop only -> EMPTY. Accept and pop together -> ONE, with the new entry becoming head.
- FULL: pop -> ONE, with the skid entry moving to head. No accept is possible.
REQ-022 up_ready_o = (state != FULL) and is driven from a register, with no combinational path from dn_ready_i.
REQ-023 dn_payload_o and dn_pc_o are all-zero whenever dn_valid_o = 0, so downstream sees a NOP bubble.
REQ-024 Branch-shadow tracker: a shadow flag and a shadow PC, both updated only on accept.
REQ-025 On accept with up_branch_tag_i = 1: set the flag and load the shadow PC with up_pc_i. This takes priority even if up_slot_end_i = 1 in the same cycle (self-loop branch).
REQ-026 On accept with up_branch_tag_i = 0, flag = 1 and up_slot_end_i = 1: clear the flag.
REQ-027 The stored PC of an accepted entry is the shadow PC if the flag was set before that accept; otherwise it is up_pc_i.
REQ-028 up_slot_end_i with the flag clear has no effect.
REQ-029 flush_i = 1 overrides any accept or pop in the same cycle. It forces EMPTY, clears the flag, and zeroes the shadow PC and all stored entries; up_ready_o = 1 in the following cycle.
REQ-030 occupancy_o equals 0, 1 or 2 for EMPTY, ONE or FULL. With SKID_EN = 0 it never exceeds 1.
REQ-031 Pop while dn_valid_o = 0 is ignored. Accept while up_ready_o = 0 is ignored and leaves the upstream entry held by the producer.

Reset
REQ-032 While n_rst_i = 0 the block is immediately, independent of the clock:
- state = EMPTY;
- dn_valid_o = 0, dn_payload_o = 0, dn_pc_o = 0;
- up_ready_o = 1, occupancy_o = 0;
- shadow flag = 0, shadow PC = 0.
REQ-033 Reset asserted mid-transfer discards all stored entries. The first accept after reset release behaves as from EMPTY.

Structure
REQ-034 The state encoding (EMPTY/ONE/FULL) and the zero-payload constant belong in the shared core package, next to the existing pipeline defines.
REQ-035 The branch-shadow tracker is one sub-module, pipe_branch_tracker. Its inputs are accept, tag, slot_end, pc and flush; its outputs are the effective PC.
REQ-036 All storage is flops; no memory macros are used.

Verification
REQ-037 Fill and drain: three back-to-back accepts of payloads 0x1, 0x2, 0x3 with dn_ready_i = 0, then dn_ready_i = 1. Required: up_ready_o drops after the 2nd accept, the 3rd is held, and 0x1, 0x2, 0x3 emerge in order with occupancy 2 -> 1 -> 0.
REQ-038 Branch shadow: accept pc 0x100 (tag = 1), then pc 0x104, then pc 0x200 (slot_end = 1), then pc 0x204. Required dn_pc_o sequence: 0x100, 0x100, 0x100, 0x204.
REQ-039 Self-loop: accept pc 0x80 with tag = 1 and slot_end = 1 on three consecutive entries. Required: every entry outputs 0x80 and the flag stays set.
REQ-040 Flush priority: in FULL state, assert flush_i together with dn_ready_i = 1 and up_valid_i = 1. Required next cycle: dn_valid_o = 0, payload = 0, occupancy 0, up_ready_o = 1, flag clear.
REQ-041 Async reset: drop n_rst_i between clock edges while in state ONE. Required: dn_valid_o = 0 and dn_pc_o = 0 immediately, with no edge needed.
REQ-042 Throughput: continuous up_valid_i = 1 and dn_ready_i = 1 for 100 cycles with SKID_EN = 0 and = 1. Required: 100 entries transferred in both cases, occupancy never 2.
